// File: rtl/pipelined_control_unit.sv
// ID-stage decoder with an owned ID/EX control register, load-use bubble insertion,
// branch flush, illegal-opcode reporting and a multi-cycle MULT hold FSM.
module pipelined_control_unit #(
  parameter int ALU_CTRL_W = 4,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_CYCLES = 4,
  parameter int ENABLE_MUL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instruction,
  input  logic                  instr_valid,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_valid,
  output logic                  ex_MemtoReg,
  output logic                  ex_RegWrite,
  output logic                  ex_MemWrite,
  output logic                  ex_MemRead,
  output logic                  ex_ALUSrc,
  output logic                  ex_RegDst,
  output logic                  ex_Jump,
  output logic                  ex_ShiftSrc,
  output logic [1:0]            ex_Branch,
  output logic [ALU_CTRL_W-1:0] ex_ALUControl,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [4:0]            ex_shamt,
  output logic [15:0]           ex_imm,
  output logic                  ex_hold,
  output logic                  illegal_instr
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam bit MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_MUL_WAIT = 1'b1;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(4'h0);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(4'h1);
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'h2);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA = ALU_CTRL_W'(4'h3);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = ALU_CTRL_W'(4'h4);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = ALU_CTRL_W'(4'h5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(4'h6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(4'h7);
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL = ALU_CTRL_W'(4'h8);
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR = ALU_CTRL_W'(4'hC);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = ALU_CTRL_W'(4'hD);
  localparam logic [ALU_CTRL_W-1:0] ALU_BUB = {ALU_CTRL_W{1'b1}};

  logic [5:0]            opcode, funct;
  logic [REG_ADDR_W-1:0] rs_f, rt_f, rd_f;
  logic                  d_legal, d_mult, d_memtoreg, d_regwrite, d_memwrite, d_memread;
  logic                  d_alusrc, d_regdst, d_shiftsrc, use_rs, use_rt;
  logic [1:0]            d_branch;
  logic [ALU_CTRL_W-1:0] d_alu;
  logic [0:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  in_wait, load_use, take, kill;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign rs_f   = REG_ADDR_W'(instruction[25:21]);
  assign rt_f   = REG_ADDR_W'(instruction[20:16]);
  assign rd_f   = REG_ADDR_W'(instruction[15:11]);

  always_comb begin
    d_legal = 1'b0; d_mult = 1'b0; d_memtoreg = 1'b0; d_regwrite = 1'b0;
    d_memwrite = 1'b0; d_memread = 1'b0; d_alusrc = 1'b0; d_regdst = 1'b0;
    d_shiftsrc = 1'b0; d_branch = 2'b00; d_alu = ALU_BUB; use_rs = 1'b0; use_rt = 1'b0;
    case (opcode)
      6'h00: begin
        d_legal = 1'b1; d_regwrite = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
        case (funct)
          6'h00: begin d_alu = ALU_SLL; d_shiftsrc = 1'b1; use_rs = 1'b0; end
          6'h02: begin d_alu = ALU_SRL; d_shiftsrc = 1'b1; use_rs = 1'b0; end
          6'h03: begin d_alu = ALU_SRA; d_shiftsrc = 1'b1; use_rs = 1'b0; end
          6'h04: d_alu = ALU_SLL;
          6'h06: d_alu = ALU_SRL;
          6'h07: d_alu = ALU_SRA;
          6'h18: begin
            d_alu = ALU_MUL; d_regwrite = 1'b0; d_mult = 1'b1;
            d_legal = (ENABLE_MUL != 0);
          end
          6'h20, 6'h21: d_alu = ALU_ADD;
          6'h22, 6'h23: d_alu = ALU_SUB;
          6'h24: d_alu = ALU_AND;
          6'h25: d_alu = ALU_OR;
          6'h26: d_alu = ALU_XOR;
          6'h27: d_alu = ALU_NOR;
          6'h2A: d_alu = ALU_SLT;
          default: begin d_legal = 1'b0; d_regwrite = 1'b0; end
        endcase
      end
      6'h23: begin
        d_legal = 1'b1; d_regwrite = 1'b1; d_alusrc = 1'b1; d_regdst = 1'b1;
        d_memread = 1'b1; d_memtoreg = 1'b1; d_alu = ALU_ADD; use_rs = 1'b1;
      end
      6'h2B: begin
        d_legal = 1'b1; d_memwrite = 1'b1; d_alusrc = 1'b1; d_alu = ALU_ADD;
        use_rs = 1'b1; use_rt = 1'b1;
      end
      6'h04, 6'h05: begin
        d_legal = 1'b1; d_alu = ALU_SUB; use_rs = 1'b1; use_rt = 1'b1;
        d_branch = opcode[0] ? 2'b10 : 2'b01;
      end
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: begin
        d_legal = 1'b1; d_regwrite = 1'b1; d_alusrc = 1'b1; d_regdst = 1'b1; use_rs = 1'b1;
        d_alu = (opcode == 6'h0C) ? ALU_AND :
                (opcode == 6'h0D) ? ALU_OR  :
                (opcode == 6'h0E) ? ALU_XOR : ALU_ADD;
      end
      default: ;
    endcase
  end

  // Only a load that really writes a non-zero register can create a load-use hazard.
  assign in_wait  = (state == S_MUL_WAIT);
  assign load_use = ~in_wait & ex_valid & ex_MemRead & ex_RegWrite & (ex_rt != '0) &
                    instr_valid & d_legal &
                    ((use_rs & (ex_rt == rs_f)) | (use_rt & (ex_rt == rt_f)));
  assign stall    = ~reset & ~flush & (in_wait | load_use);
  assign take     = ~flush & ~in_wait & ~load_use & instr_valid & d_legal;
  assign kill     = flush | (~in_wait & ~take);
  assign ex_hold  = in_wait;

  always_ff @(posedge clk) begin
    if (reset || kill) begin
      ex_valid <= 1'b0; ex_MemtoReg <= 1'b0; ex_RegWrite <= 1'b0; ex_MemWrite <= 1'b0;
      ex_MemRead <= 1'b0; ex_ALUSrc <= 1'b0; ex_RegDst <= 1'b0; ex_Jump <= 1'b0;
      ex_ShiftSrc <= 1'b0; ex_Branch <= 2'b00; ex_ALUControl <= ALU_BUB;
      ex_rs <= '0; ex_rt <= '0; ex_rd <= '0; ex_shamt <= '0; ex_imm <= '0;
    end else if (take) begin
      ex_valid <= 1'b1; ex_MemtoReg <= d_memtoreg; ex_RegWrite <= d_regwrite;
      ex_MemWrite <= d_memwrite; ex_MemRead <= d_memread; ex_ALUSrc <= d_alusrc;
      ex_RegDst <= d_regdst; ex_Jump <= 1'b0; ex_ShiftSrc <= d_shiftsrc;
      ex_Branch <= d_branch; ex_ALUControl <= d_alu;
      ex_rs <= rs_f; ex_rt <= rt_f; ex_rd <= rd_f;
      ex_shamt <= instruction[10:6]; ex_imm <= instruction[15:0];
    end
  end

  // Counter holds the number of hold cycles still to go; MULT stays in EX throughout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      illegal_instr <= 1'b0;
    end else begin
      illegal_instr <= ~flush & ~in_wait & ~load_use & instr_valid & ~d_legal;
      if (flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else if (in_wait) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state <= S_IDLE;
      end else if (take && d_mult && MUL_MULTI) begin
        state <= S_MUL_WAIT;
        cnt   <= MUL_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Randomized scoreboard bench for pipelined_control_unit against a mnemonic-level reference model.
module tb_pipelined_control_unit;
  localparam int MULC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, instr_valid, flush;
  logic [31:0] instruction;
  logic        stall, ex_valid, ex_MemtoReg, ex_RegWrite, ex_MemWrite, ex_MemRead;
  logic        ex_ALUSrc, ex_RegDst, ex_Jump, ex_ShiftSrc, ex_hold, illegal_instr;
  logic [1:0]  ex_Branch;
  logic [3:0]  ex_ALUControl;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [15:0] ex_imm;

  pipelined_control_unit #(.ALU_CTRL_W(4), .REG_ADDR_W(5), .MUL_CYCLES(MULC), .ENABLE_MUL(1)) u_dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
    .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead), .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst),
    .ex_Jump(ex_Jump), .ex_ShiftSrc(ex_ShiftSrc), .ex_Branch(ex_Branch), .ex_ALUControl(ex_ALUControl),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_imm(ex_imm),
    .ex_hold(ex_hold), .illegal_instr(illegal_instr));

  // Second instance with MULT disabled
  logic        reset2, instr_valid2, flush2;
  logic [31:0] instruction2;
  logic        stall2, ex_valid2, ex_MemtoReg2, ex_RegWrite2, ex_MemWrite2, ex_MemRead2;
  logic        ex_ALUSrc2, ex_RegDst2, ex_Jump2, ex_ShiftSrc2, ex_hold2, illegal_instr2;
  logic [1:0]  ex_Branch2;
  logic [3:0]  ex_ALUControl2;
  logic [4:0]  ex_rs2, ex_rt2, ex_rd2, ex_shamt2;
  logic [15:0] ex_imm2;

  pipelined_control_unit #(.ALU_CTRL_W(4), .REG_ADDR_W(5), .MUL_CYCLES(MULC), .ENABLE_MUL(0)) u_nomul (
    .clk(clk), .reset(reset2), .instruction(instruction2), .instr_valid(instr_valid2), .flush(flush2),
    .stall(stall2), .ex_valid(ex_valid2), .ex_MemtoReg(ex_MemtoReg2), .ex_RegWrite(ex_RegWrite2),
    .ex_MemWrite(ex_MemWrite2), .ex_MemRead(ex_MemRead2), .ex_ALUSrc(ex_ALUSrc2), .ex_RegDst(ex_RegDst2),
    .ex_Jump(ex_Jump2), .ex_ShiftSrc(ex_ShiftSrc2), .ex_Branch(ex_Branch2), .ex_ALUControl(ex_ALUControl2),
    .ex_rs(ex_rs2), .ex_rt(ex_rt2), .ex_rd(ex_rd2), .ex_shamt(ex_shamt2), .ex_imm(ex_imm2),
    .ex_hold(ex_hold2), .illegal_instr(illegal_instr2));

  typedef struct packed {
    logic        valid, memtoreg, regwrite, memwrite, memread, alusrc, regdst, jump, shiftsrc;
    logic [1:0]  branch;
    logic [3:0]  alu;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
  } ex_t;

  typedef struct { ex_t ex; logic hold; logic ill; } obs_t;
  typedef struct { logic [31:0] ins; logic v; int flc; } ent_t;

  ex_t  dut_ex;
  assign dut_ex = {ex_valid, ex_MemtoReg, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, ex_RegDst,
                   ex_Jump, ex_ShiftSrc, ex_Branch, ex_ALUControl, ex_rs, ex_rt, ex_rd, ex_shamt, ex_imm};

  obs_t out_q[$];
  bit   stall_q[$];
  ent_t prog[$];
  int   n_cmp = 0;
  int   n_err = 0;

  ex_t  m_ex;
  int   m_left;
  logic m_ill;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ex_t bubble();
    ex_t b = '0;
    b.alu = 4'hF;
    return b;
  endfunction

  function automatic string mnem(input logic [31:0] i);
    case (i[31:26])
      6'h23: return "lw";
      6'h2B: return "sw";
      6'h04: return "beq";
      6'h05: return "bne";
      6'h08: return "addi";
      6'h09: return "addiu";
      6'h0C: return "andi";
      6'h0D: return "ori";
      6'h0E: return "xori";
      6'h00: case (i[5:0])
        6'h00: return "sll";  6'h02: return "srl";  6'h03: return "sra";
        6'h04: return "sllv"; 6'h06: return "srlv"; 6'h07: return "srav";
        6'h18: return "mult";
        6'h20: return "add";  6'h21: return "addu"; 6'h22: return "sub"; 6'h23: return "subu";
        6'h24: return "and";  6'h25: return "or";   6'h26: return "xor"; 6'h27: return "nor";
        6'h2A: return "slt";
        default: return "";
      endcase
      default: return "";
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input string m);
    if (m == "add" || m == "addu" || m == "lw" || m == "sw" || m == "addi" || m == "addiu") return 4'h2;
    if (m == "sub" || m == "subu" || m == "beq" || m == "bne") return 4'h6;
    if (m == "and" || m == "andi") return 4'h0;
    if (m == "or" || m == "ori") return 4'h1;
    if (m == "nor") return 4'hC;
    if (m == "xor" || m == "xori") return 4'hD;
    if (m == "slt") return 4'h7;
    if (m == "sll" || m == "sllv") return 4'h4;
    if (m == "srl" || m == "srlv") return 4'h5;
    if (m == "sra" || m == "srav") return 4'h3;
    if (m == "mult") return 4'h8;
    return 4'hF;
  endfunction

  function automatic void ref_decode(input logic [31:0] i, output bit legal, output ex_t d,
                                     output bit urs, output bit urt, output bit is_mult);
    string m;
    bit is_r, sh, imm_op;
    m = mnem(i);
    d = bubble(); legal = (m != ""); urs = 0; urt = 0; is_mult = (m == "mult");
    if (!legal) return;
    is_r   = (i[31:26] == 6'h00);
    sh     = (m == "sll" || m == "srl" || m == "sra");
    imm_op = (m == "addi" || m == "addiu" || m == "andi" || m == "ori" || m == "xori");
    d.valid = 1; d.alu = alu_of(m);
    d.rs = i[25:21]; d.rt = i[20:16]; d.rd = i[15:11]; d.shamt = i[10:6]; d.imm = i[15:0];
    d.regwrite = (is_r && m != "mult") || imm_op || m == "lw";
    d.alusrc   = imm_op || m == "lw" || m == "sw";
    d.regdst   = imm_op || m == "lw";
    d.memread  = (m == "lw");
    d.memtoreg = (m == "lw");
    d.memwrite = (m == "sw");
    d.branch   = (m == "beq") ? 2'b01 : (m == "bne") ? 2'b10 : 2'b00;
    d.shiftsrc = sh;
    urs = !sh;
    urt = is_r || m == "beq" || m == "bne" || m == "sw";
  endfunction

  // One clock of stimulus: drive inputs, predict stall now and outputs after the next edge.
  task automatic step(input logic r, input logic [31:0] ins, input logic v, input logic f,
                      input bit chk_st, output bit st);
    bit legal, urs, urt, is_mult, lu;
    ex_t d;
    obs_t o;
    @(negedge clk);
    reset = r; instruction = ins; instr_valid = v; flush = f;
    ref_decode(ins, legal, d, urs, urt, is_mult);
    lu = !r && !f && m_left == 0 && m_ex.valid && m_ex.memread && m_ex.regwrite && m_ex.rt != 0 &&
         v && legal && ((urs && d.rs == m_ex.rt) || (urt && d.rt == m_ex.rt));
    st = !r && !f && (m_left > 0 || lu);
    if (chk_st) stall_q.push_back(st);
    m_ill = 1'b0;
    if (r || f) begin
      m_ex = bubble(); m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (lu) begin
      m_ex = bubble();
    end else if (v && legal) begin
      m_ex = d;
      if (is_mult) m_left = MULC - 1;
    end else begin
      m_ex = bubble();
      m_ill = v;
    end
    o.ex = m_ex; o.hold = (m_left > 0); o.ill = m_ill;
    out_q.push_back(o);
  endtask

  task automatic add_ent(input logic [31:0] ins, input logic v, input int flc);
    ent_t e;
    e.ins = ins; e.v = v; e.flc = flc;
    prog.push_back(e);
  endtask

  function automatic logic [31:0] r_ty(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_ty(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  always begin
    @(posedge clk); #1;
    if (out_q.size() > 0) begin
      obs_t o;
      o = out_q.pop_front();
      chk("ex_bundle", dut_ex, o.ex);
      chk("ex_hold", ex_hold, o.hold);
      chk("illegal_instr", illegal_instr, o.ill);
    end
  end

  always begin
    @(negedge clk); #1;
    if (stall_q.size() > 0) chk("stall", stall, stall_q.pop_front());
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    logic [5:0] rf[14];
    logic [5:0] io[5];
    logic [5:0] bo[3];
    rf = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A};
    io = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E};
    bo = '{6'h3F, 6'h02, 6'h0A};
    m_ex = bubble(); m_left = 0; m_ill = 0;
    reset = 1; instruction = 32'h0; instr_valid = 1; flush = 0;
    reset2 = 1; instruction2 = 32'h0; instr_valid2 = 0; flush2 = 0;
    @(posedge clk);
    step(1, 32'h0, 1, 0, 1, st);
    step(1, 32'h0, 1, 0, 1, st);

    add_ent(32'h0000_0000, 1, -1);                  // sll $0,$0,0
    add_ent(32'h8E08_0000, 1, -1);                  // lw $t0,0($s0)
    add_ent(32'h010A_4820, 1, -1);                  // add $t1,$t0,$t2
    add_ent(32'h8E00_0000, 1, -1);                  // lw $0,0($s0)
    add_ent(r_ty(0, 10, 9, 0, 6'h20), 1, -1);
    add_ent(32'h1109_0003, 1, -1);                  // beq
    add_ent(32'h0000_0000, 1, 0);                   // flush while beq in EX
    add_ent(r_ty(8, 9, 0, 0, 6'h18), 1, -1);        // mult full run
    add_ent(32'h010A_4820, 1, -1);
    add_ent(r_ty(8, 9, 0, 0, 6'h18), 1, -1);        // mult aborted on 2nd hold cycle
    add_ent(32'h010A_4820, 1, 1);
    add_ent(32'h0000_0000, 0, -1);
    add_ent(32'hFC00_0000, 1, -1);                  // opcode 0x3F
    add_ent(32'h0000_0000, 1, -1);
    add_ent(i_ty(6'h08, 16, 8, 16'h0005), 1, -1);   // addi
    add_ent(i_ty(6'h2B, 16, 8, 16'h0004), 1, -1);   // sw
    add_ent(i_ty(6'h05, 8, 9, 16'hFFFE), 1, -1);    // bne

    for (int n = 0; n < 1500; n++) begin
      int k, a, b, c, fr;
      logic [31:0] ins;
      k = $urandom_range(0, 9);
      a = $urandom_range(0, 3); b = $urandom_range(0, 3); c = $urandom_range(0, 3);
      case (k)
        0: ins = i_ty(6'h23, a, b, 16'($urandom));
        1: ins = i_ty(6'h2B, a, b, 16'($urandom));
        2: ins = i_ty($urandom_range(0, 1) ? 6'h04 : 6'h05, a, b, 16'($urandom));
        3: ins = i_ty(io[$urandom_range(0, 4)], a, b, 16'($urandom));
        4, 5: ins = r_ty(a, b, c, $urandom_range(0, 31), rf[$urandom_range(0, 13)]);
        6: ins = r_ty(a, b, 0, 0, 6'h18);
        7: ins = $urandom_range(0, 1) ? i_ty(bo[$urandom_range(0, 2)], a, b, 16'($urandom))
                                      : r_ty(a, b, c, 0, 6'h3F);
        default: ins = r_ty(a, b, c, $urandom_range(0, 31), 6'h20);
      endcase
      fr = $urandom_range(0, 19);
      add_ent(ins, ($urandom_range(0, 9) != 0), (fr == 0) ? 0 : (fr == 1) ? 1 : -1);
    end

    while (prog.size() > 0) begin
      ent_t e;
      int cyc;
      e = prog.pop_front();
      cyc = 0;
      forever begin
        step(0, e.ins, e.v, (e.flc == cyc), 1, st);
        if (!st) break;
        cyc++;
        if (cyc > 64) begin
          chk("stall_bound", 64'(cyc), 64'd0);
          break;
        end
      end
    end
    for (int n = 0; n < 4; n++) step(0, 32'h0, 0, 0, 1, st);
    @(posedge clk); #2;
    chk("queue_drain", 64'(out_q.size() + stall_q.size()), 64'd0);

    // MULT-disabled instance: MULT is illegal and never holds
    @(negedge clk); reset2 = 1; instr_valid2 = 1; instruction2 = 32'h0;
    @(posedge clk); #1;
    chk("nm_reset_alu", ex_ALUControl2, 4'hF);
    chk("nm_reset_valid", ex_valid2, 1'b0);
    @(negedge clk); reset2 = 0; instruction2 = r_ty(8, 9, 0, 0, 6'h18);
    @(posedge clk); #1;
    chk("nm_mult_illegal", illegal_instr2, 1'b1);
    chk("nm_mult_hold", ex_hold2, 1'b0);
    chk("nm_mult_valid", ex_valid2, 1'b0);
    chk("nm_mult_regwrite", ex_RegWrite2, 1'b0);
    @(negedge clk);
    chk("nm_stall", stall2, 1'b0);
    instruction2 = 32'h010A_4820;
    @(posedge clk); #1;
    chk("nm_pulse_end", illegal_instr2, 1'b0);
    chk("nm_add_valid", ex_valid2, 1'b1);
    chk("nm_add_alu", ex_ALUControl2, 4'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
